// File: rtl/ifq_pkg.sv
// Shared types and default widths for the instruction fetch queue.
// The IFQ_BYPASS_EN option is consumed by instruction_fetch_queue, not here.
package ifq_pkg;

   typedef enum logic [1:0] {
      IFQ_IDLE    = 2'd0,
      IFQ_WAIT    = 2'd1,
      IFQ_DISCARD = 2'd2
   } ifq_state_t;

   localparam int IFQ_ADDR_W = 5;
   localparam int IFQ_DATA_W = 32;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries for the decode stage.
// Clear wins over push/pop; pop on empty and push on full are ignored.
module ifq_fifo #(
   parameter  int WIDTH = 37,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign do_pop  = pop_i & ~empty_o & ~clear_i;
   assign do_push = push_i & (~full | do_pop) & ~clear_i;

   // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clear_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + 1'b1;
         if (do_pop)  rptr_d = rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // NOTE: storage is not reset; the read port is forced to zero while empty instead.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch queue: one outstanding instruction read per accepted PC, results buffered for decode.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module instruction_fetch_queue
   import ifq_pkg::*;
#(
   parameter int ADDR_W = IFQ_ADDR_W,
   parameter int DATA_W = IFQ_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              pc_valid,
   output logic              pc_ready,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   input  logic              flush,
   output logic [DATA_W-1:0] ins_out,
   output logic [ADDR_W-1:0] ins_pc,
   output logic              ins_valid,
   input  logic              ins_ready
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   ifq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

   logic                     fifo_push;
   logic                     fifo_pop;
   logic                     fifo_empty;
   logic [CNT_W-1:0]         fifo_count;
   logic [ADDR_W+DATA_W-1:0] fifo_rdata;
   logic                     bypass_take;
   logic                     pc_fire;

`ifdef IFQ_BYPASS_EN
   assign bypass_take = (state_q == IFQ_WAIT) & mem_rvalid & ~flush & fifo_empty & ins_ready;
`else
   assign bypass_take = 1'b0;
`endif

   // The slot for the outstanding read is reserved because requests are only taken in IDLE.
   assign pc_ready = (state_q == IFQ_IDLE) & (fifo_count < FULL_CNT) & ~flush;
   assign pc_fire  = pc_valid & pc_ready;

   always_comb begin
      state_d    = state_q;
      req_pc_d   = req_pc_q;
      mem_req_d  = 1'b0;
      mem_addr_d = mem_addr_q;
      fifo_push  = 1'b0;
      if (flush) begin
         // A response landing in the flush cycle is dropped here, otherwise DISCARD would never exit.
         if (mem_rvalid && state_q != IFQ_IDLE) state_d = IFQ_IDLE;
         else if (state_q == IFQ_WAIT)          state_d = IFQ_DISCARD;
      end else begin
         unique case (state_q)
            IFQ_IDLE: begin
               if (pc_fire) begin
                  state_d    = IFQ_WAIT;
                  req_pc_d   = pc_in;
                  mem_req_d  = 1'b1;
                  mem_addr_d = pc_in;
               end
            end
            IFQ_WAIT: begin
               if (mem_rvalid) begin
                  state_d   = IFQ_IDLE;
                  fifo_push = ~bypass_take;
               end
            end
            IFQ_DISCARD: begin
               if (mem_rvalid) state_d = IFQ_IDLE;
            end
            default: state_d = IFQ_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IFQ_IDLE;
         req_pc_q   <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         req_pc_q   <= req_pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign fifo_pop = ins_ready & ~fifo_empty;

   ifq_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear_i (flush),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i ({req_pc_q, mem_rdata}),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign ins_valid = bypass_take | ~fifo_empty;
   assign {ins_pc, ins_out} = bypass_take ? {req_pc_q, mem_rdata} : fifo_rdata;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue with a latency-programmable memory model
// and a scoreboard of expected {pc, word} pairs; honours IFQ_BYPASS_EN when defined.
module tb_instruction_fetch_queue;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
`ifdef IFQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] pc_in;
   logic              pc_valid;
   logic              pc_ready;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;
   logic              flush;
   logic [DATA_W-1:0] ins_out;
   logic [ADDR_W-1:0] ins_pc;
   logic              ins_valid;
   logic              ins_ready;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t              exp_q[$];
   int                checks  = 0;
   int                errors  = 0;
   int                pop_cnt = 0;
   int                mem_lat = 2;
   int                pend_cnt = 0;
   logic [ADDR_W-1:0] pend_addr = '0;

   instruction_fetch_queue #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_in      (pc_in),
      .pc_valid   (pc_valid),
      .pc_ready   (pc_ready),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .flush      (flush),
      .ins_out    (ins_out),
      .ins_pc     (ins_pc),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready)
   );

   always #5 clk = ~clk;

   // Memory contents: word at address a is A5A5_0000 | (a ^ 5), so address 4 holds A5A5_0001.
   function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      return 32'hA5A5_0000 | {27'b0, a ^ 5'd5};
   endfunction

   // Memory model: answers each request mem_lat cycles after the mem_req cycle. It keeps
   // counting through a DUT reset so that a stale response can arrive afterwards.
   initial begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = mem_word(pend_addr);
            end
         end
         if (mem_req && !reset) begin
            pend_cnt  = mem_lat;
            pend_addr = mem_addr;
         end
      end
   end

   // Scoreboard: expectations are queued at each PC handshake and compared at each pop.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset) begin
         if (pc_valid && pc_ready) exp_q.push_back(exp_t'{pc: pc_in, data: mem_word(pc_in)});
         if (flush) begin
            exp_q.delete();
         end else if (ins_valid && ins_ready) begin
            checks++;
            pop_cnt++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_extra: got pc=%0d data=%h, required no output", ins_pc, ins_out);
            end else begin
               e = exp_q.pop_front();
               if ({ins_pc, ins_out} !== {e.pc, e.data}) begin
                  errors++;
                  $display("FAIL scoreboard_data: got pc=%0d data=%h, required pc=%0d data=%h",
                           ins_pc, ins_out, e.pc, e.data);
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic fetch(input logic [ADDR_W-1:0] pc);
      int n = 0;
      pc_in    = pc;
      pc_valid = 1'b1;
      while (!pc_ready && n < 50) begin
         cyc();
         n++;
      end
      checks++;
      if (pc_ready !== 1'b1) begin
         errors++;
         $display("FAIL fetch_accept: pc_ready=%b required 1 for pc %0d", pc_ready, pc);
      end
      cyc();
      pc_valid = 1'b0;
   endtask

   task automatic wait_rvalid();
      int n = 0;
      while (!mem_rvalid && n < 20) begin
         cyc();
         n++;
      end
      checks++;
      if (mem_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL wait_rvalid: no response within 20 cycles (mem_req never seen?)");
      end
   endtask

   task automatic drain();
      int n = 0;
      ins_ready = 1'b1;
      while ((exp_q.size() != 0 || ins_valid) && n < 60) begin
         cyc();
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || ins_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain: %0d entries pending, ins_valid=%b, required 0 and 0", exp_q.size(), ins_valid);
      end
      ins_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; pc_in = '0; pc_valid = 1'b0; flush = 1'b0; ins_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checks += 6;
      if (mem_req !== 1'b0)    begin errors++; $display("FAIL reset_mem_req: got %b required 0", mem_req); end
      if (mem_addr !== '0)     begin errors++; $display("FAIL reset_mem_addr: got %0d required 0", mem_addr); end
      if (pc_ready !== 1'b1)   begin errors++; $display("FAIL reset_pc_ready: got %b required 1", pc_ready); end
      if (ins_valid !== 1'b0)  begin errors++; $display("FAIL reset_ins_valid: got %b required 0", ins_valid); end
      if (ins_out !== '0)      begin errors++; $display("FAIL reset_ins_out: got %h required 0", ins_out); end
      if (ins_pc !== '0)       begin errors++; $display("FAIL reset_ins_pc: got %0d required 0", ins_pc); end
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_single_fetch();
      mem_lat = 2; ins_ready = 1'b0;
      pc_in = 5'd4; pc_valid = 1'b1;
      checks++;
      if (pc_ready !== 1'b1) begin errors++; $display("FAIL single_accept: pc_ready=%b required 1", pc_ready); end
      cyc();
      pc_valid = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 5'd4) begin
         errors++;
         $display("FAIL single_req: mem_req=%b mem_addr=%0d required 1 and 4", mem_req, mem_addr);
      end
      cyc();
      checks++;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL single_req_pulse: mem_req=%b required 0", mem_req); end
      cyc();
      checks++;
      if (ins_valid !== 1'b0) begin errors++; $display("FAIL single_not_yet: ins_valid=%b required 0", ins_valid); end
      cyc();
      checks++;
      if (ins_valid !== 1'b1 || ins_pc !== 5'd4 || ins_out !== 32'hA5A5_0001 || pc_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_out: valid=%b pc=%0d out=%h pc_ready=%b required 1, 4, a5a50001, 1",
                  ins_valid, ins_pc, ins_out, pc_ready);
      end
      ins_ready = 1'b1;
      cyc();
      ins_ready = 1'b0;
      checks++;
      if (ins_valid !== 1'b0) begin errors++; $display("FAIL single_popped: ins_valid=%b required 0", ins_valid); end
   endtask

   task automatic test_fill_backpressure();
      int acc = 0;
      int p = 0;
      int pops0;
      int n = 0;
      logic hs;
      mem_lat = 1; ins_ready = 1'b0;
      pc_in = '0; pc_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         hs = pc_ready;
         cyc();
         if (hs) begin
            acc++;
            if (p < 5) p++;
            pc_in = 5'(p);
         end
      end
      checks++;
      if (acc != 4 || pc_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_accepts: accepted=%0d pc_ready=%b required 4 and 0", acc, pc_ready);
      end
      checks++;
      if (ins_valid !== 1'b1 || ins_pc !== 5'd0) begin
         errors++;
         $display("FAIL fill_head: valid=%b pc=%0d required 1 and 0", ins_valid, ins_pc);
      end
      pc_valid = 1'b0;
      pops0 = pop_cnt;
      ins_ready = 1'b1;
      while (ins_valid && n < 20) begin
         cyc();
         n++;
      end
      ins_ready = 1'b0;
      checks++;
      if (pop_cnt - pops0 != 4 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL fill_release: popped=%0d pending=%0d required 4 and 0", pop_cnt - pops0, exp_q.size());
      end
   endtask

   task automatic test_flush();
      int n = 0;
      bit saw = 1'b0;
      mem_lat = 1; ins_ready = 1'b0;
      fetch(5'd1);
      fetch(5'd2);
      repeat (3) cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      checks++;
      if (ins_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: ins_valid=%b required 0", ins_valid); end

      mem_lat = 3; ins_ready = 1'b1;
      fetch(5'd7);
      cyc();
      flush = 1'b1;
      checks++;
      if (pc_ready !== 1'b0) begin errors++; $display("FAIL flush_pc_ready: pc_ready=%b required 0", pc_ready); end
      cyc();
      flush = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (ins_valid) saw = 1'b1;
         cyc();
      end
      checks++;
      if (saw) begin errors++; $display("FAIL flush_discard: ins_valid seen=1 required 0"); end

      mem_lat = 1;
      fetch(5'd9);
      while (!ins_valid && n < 10) begin
         cyc();
         n++;
      end
      checks++;
      if (ins_valid !== 1'b1 || ins_pc !== 5'd9 || ins_out !== mem_word(5'd9)) begin
         errors++;
         $display("FAIL flush_next: valid=%b pc=%0d out=%h required 1, 9, %h", ins_valid, ins_pc, ins_out, mem_word(5'd9));
      end
      cyc();
      ins_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      mem_lat = 1; ins_ready = 1'b0;
      fetch(5'd20);
      fetch(5'd21);
      repeat (3) cyc();
      checks++;
      if (dut.u_fifo.count_o !== 3'd2) begin
         errors++;
         $display("FAIL b2b_prefill: count=%0d required 2", dut.u_fifo.count_o);
      end
      for (int k = 0; k < 10; k++) begin
         fetch(5'(10 + k));
         wait_rvalid();
         ins_ready = 1'b1;
         cyc();
         ins_ready = 1'b0;
         checks++;
         if (dut.u_fifo.count_o !== 3'd2) begin
            errors++;
            $display("FAIL b2b_count: fetch %0d count=%0d required 2", k, dut.u_fifo.count_o);
         end
      end
      drain();
   endtask

   task automatic test_async_reset();
      bit saw = 1'b0;
      mem_lat = 1; ins_ready = 1'b0;
      fetch(5'd3);
      fetch(5'd4);
      fetch(5'd5);
      repeat (3) cyc();
      mem_lat = 8;
      fetch(5'd6);
      checks++;
      if (mem_req !== 1'b1 || dut.u_fifo.count_o !== 3'd3) begin
         errors++;
         $display("FAIL areset_setup: mem_req=%b count=%0d required 1 and 3", mem_req, dut.u_fifo.count_o);
      end
      #1 reset = 1'b1;
      exp_q.delete();
      #1;
      checks += 6;
      if (mem_req !== 1'b0)    begin errors++; $display("FAIL areset_mem_req: got %b required 0", mem_req); end
      if (mem_addr !== '0)     begin errors++; $display("FAIL areset_mem_addr: got %0d required 0", mem_addr); end
      if (pc_ready !== 1'b1)   begin errors++; $display("FAIL areset_pc_ready: got %b required 1", pc_ready); end
      if (ins_valid !== 1'b0)  begin errors++; $display("FAIL areset_ins_valid: got %b required 0", ins_valid); end
      if (ins_out !== '0)      begin errors++; $display("FAIL areset_ins_out: got %h required 0", ins_out); end
      if (ins_pc !== '0)       begin errors++; $display("FAIL areset_ins_pc: got %0d required 0", ins_pc); end
      @(negedge clk);
      #1 reset = 1'b0;
      ins_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (ins_valid) saw = 1'b1;
      end
      checks++;
      if (saw || dut.u_fifo.count_o !== 3'd0 || pc_ready !== 1'b1) begin
         errors++;
         $display("FAIL areset_late_rvalid: valid_seen=%b count=%0d pc_ready=%b required 0, 0, 1",
                  saw, dut.u_fifo.count_o, pc_ready);
      end
      ins_ready = 1'b0;
   endtask

   task automatic test_bypass_latency();
      mem_lat = 2; ins_ready = 1'b1;
      fetch(5'd3);
      wait_rvalid();
      checks++;
      if (ins_valid !== BYP) begin
         errors++;
         $display("FAIL bypass_same_cycle: ins_valid=%b required %b", ins_valid, BYP);
      end
      if (BYP) begin
         checks++;
         if (ins_pc !== 5'd3 || ins_out !== mem_word(5'd3)) begin
            errors++;
            $display("FAIL bypass_data: pc=%0d out=%h required 3 and %h", ins_pc, ins_out, mem_word(5'd3));
         end
      end
      cyc();
      checks++;
      if (ins_valid !== !BYP) begin
         errors++;
         $display("FAIL bypass_next_cycle: ins_valid=%b required %b", ins_valid, !BYP);
      end
      cyc();
      checks++;
      if (ins_valid !== 1'b0) begin errors++; $display("FAIL bypass_drained: ins_valid=%b required 0", ins_valid); end
      ins_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_fill_backpressure();
      test_flush();
      test_back_to_back();
      test_async_reset();
      test_bypass_latency();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: %0d entries never delivered, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Consumer side of the program-counter path: accepts PC values from `increment_program_counter` through a valid/ready handshake and issues one instruction-memory read per accepted PC. It buffers the returned instruction words, each tagged with its PC, in a small FIFO for the decode stage. A `flush` discards everything in flight, for branch redirects.

## Interface
Parameters:
- `ADDR_W`, default 5: PC / memory address width.
- `DATA_W`, default 32: instruction word width.
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_in`  in  ADDR_W  PC to fetch.
- `pc_valid`  in  1  `pc_in` is valid.
- `pc_ready`  out  1  PC accepted on a cycle where `pc_valid & pc_ready`.
- `mem_req`  out  1  one-cycle read request pulse.
- `mem_addr`  out  ADDR_W  read address; valid while `mem_req`.
- `mem_rdata`  in  DATA_W  read data.
- `mem_rvalid`  in  1  read data valid, one pulse per request.
- `flush`  in  1  drop the FIFO contents and the in-flight read.
- `ins_out`  out  DATA_W  instruction word at the FIFO head.
- `ins_pc`  out  ADDR_W  PC of `ins_out`.
- `ins_valid`  out  1  FIFO head valid.
- `ins_ready`  in  1  decode consumes the head on `ins_valid & ins_ready`.

## Operation
- FSM states and transitions:
  - IDLE: no read outstanding.
  - WAIT: one read outstanding.
  - DISCARD: outstanding read was flushed; its response is dropped.
- IDLE→WAIT on a PC handshake. The PC is latched into `req_pc`, and `mem_req`/`mem_addr` are driven from registers the next cycle.
- WAIT→IDLE on `mem_rvalid`. `{req_pc, mem_rdata}` is pushed into the FIFO.
- `pc_ready` = (state==IDLE) & (count < DEPTH) & ~flush. A push slot is therefore always reserved for the outstanding read, so the FIFO never overflows.
- At most one read is outstanding at any time.
- Pop on `ins_valid & ins_ready`.
  - Push and pop may occur in the same cycle; `count` is then unchanged.
  - Pop while empty is ignored.
- `flush` (takes priority over all other events in that cycle):
  - Clears `count` and the read/write pointers.
  - WAIT→DISCARD; IDLE stays IDLE.
  - No handshake is accepted in a flush cycle.
- DISCARD→IDLE on `mem_rvalid`; that data is not pushed.
- `flush` while in DISCARD keeps the FSM in DISCARD.
- `mem_rvalid` outside WAIT/DISCARD is ignored.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally. `count` is `$clog2(DEPTH)+1` bits wide.

## Timing
- Reset values: state=IDLE, `count`=0, pointers=0, `mem_req`=0, `mem_addr`=0, `pc_ready`=1, `ins_valid`=0, `ins_out`=0, `ins_pc`=0.
- PC handshake at edge t → `mem_req`=1 for exactly the cycle after t.
- Memory latency is ≥1 cycle after `mem_req` and otherwise unbounded.
- `mem_rvalid` in cycle r → `ins_valid` is 1 in cycle r+1 (registered FIFO); see Configuration for the bypass exception.
- After `mem_rvalid` in cycle r, `pc_ready` is high again in cycle r+1 if space remains.
- Best case for back-to-back fetches is one PC every 3 cycles (accept, request, response).
- `flush` in cycle f → `ins_valid`=0 in cycle f+1.
- Reset asserted mid-operation returns all state to reset values immediately, without waiting for a clock edge.

## Configuration
- `IFQ_BYPASS_EN`:
  - Defined: when the FIFO is empty, the response is not being discarded, and `ins_ready`=1, the response is forwarded combinationally. In the `mem_rvalid` cycle, `ins_valid`=1, `ins_out`=`mem_rdata` and `ins_pc`=`req_pc`, and no push occurs.
  - Undefined: every response goes through the FIFO, with one cycle of added latency.

## Structure
- Shared package `ifq_pkg`:
  - State enum `ifq_state_t` {IFQ_IDLE, IFQ_WAIT, IFQ_DISCARD}.
  - Default width constants `IFQ_ADDR_W`=5, `IFQ_DATA_W`=32.
- Natural sub-module: `ifq_fifo`, a synchronous DEPTH×(ADDR_W+DATA_W) FIFO with push, pop, clear, count, and async reset.
- The top level contains the FSM, the request registers and the optional bypass mux.

## Test plan
- Reset, then PC=5'b00100 with memory latency 2 and data 32'hA5A5_0001 → `mem_req` one cycle after accept with `mem_addr`=4, then `ins_valid` with `ins_pc`=4 and `ins_out`=32'hA5A5_0001.
- `ins_ready`=0, PCs 0..5 offered continuously → exactly 4 accepted (PCs 0..3) and `pc_ready` stays 0; release `ins_ready` → PCs pop out in order 0,1,2,3.
- `flush` in the cycle after `mem_req` for PC=7, response arrives 3 cycles later → no `ins_valid`; next accepted PC=9 is delivered with `ins_pc`=9.
- Simultaneous push and pop with `count`=2 → `count` stays 2 and pointers wrap correctly across 10 fetches.
- Async `reset` pulse between edges while in WAIT with `count`=3 → all outputs at reset values before the next edge, and a late `mem_rvalid` is ignored.
- With `IFQ_BYPASS_EN`, empty FIFO and `ins_ready`=1 → `ins_valid` is high in the same cycle as `mem_rvalid`; without the macro it is high one cycle later.
